// File: rtl/clint_rtc_pkg.sv
// clint_rtc_pkg: shared types and constants for the CLINT RTC generator
//   cfg_state_e      config FSM states
//   rtc_inc()        increment = 2^acc_width * 2 * f_rtc / f_aclk, rounded to nearest
//   RTC_* constants  default width, minimum half period, default increment
package clint_rtc_pkg;
  typedef enum logic {CFG_IDLE, CFG_SHADOW} cfg_state_e;
  function automatic logic [63:0] rtc_inc(input int unsigned acc_width, input logic [63:0] f_rtc, input logic [63:0] f_aclk);
    return ((64'd1 << acc_width) * 64'd2 * f_rtc + f_aclk / 64'd2) / f_aclk;
  endfunction
  localparam int RTC_ACC_WIDTH = 32;
  localparam int RTC_MIN_HALF_PERIOD = 2;
  localparam logic [31:0] RTC_DEFAULT_INC = 32'(rtc_inc(32, 64'd1_000_000, 64'd50_000_000));
endpackage

// File: rtl/clint_rtc_gen_phase_acc.sv
// rtc_phase_acc: phase accumulator whose carry out marks one RTC toggle request
//   clk, rst  clock, async active-high reset
//   enable    1 = advance by inc each cycle, 0 = hold (carry forced low)
//   inc       phase increment
//   carry     bit W of acc + inc, valid in the cycle before the edge that wraps acc
module rtc_phase_acc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [W-1:0] inc,
  output logic         carry
);
  logic [W-1:0] acc;
  logic [W:0]   sum;
  assign sum = {1'b0, acc} + {1'b0, inc};
  assign carry = enable & sum[W];
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else if (enable) acc <= sum[W-1:0];
endmodule

// File: rtl/clint_rtc_gen.sv
// clint_rtc_gen: fractional-rate RTC square wave for the CLINT, with runtime increment update
//   aclk, areset   clock, async active-high reset
//   enable_i       1 = run, 0 = freeze phase and level
//   cfg_valid_i/cfg_ready_o/cfg_inc_i  increment config handshake
//   rtc_o          square wave, each level held >= MIN_HALF_PERIOD cycles
//   tick_o         one-cycle pulse with each rising toggle
//   tick_count_o   rising toggle count (wraps)
//   overrun_o      sticky dropped-carry flag, cleared by an accepted config
module clint_rtc_gen import clint_rtc_pkg::*; #(
  parameter int                   ACC_WIDTH       = RTC_ACC_WIDTH,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_INC     = ACC_WIDTH'(RTC_DEFAULT_INC),
  parameter int                   MIN_HALF_PERIOD = RTC_MIN_HALF_PERIOD
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 enable_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [ACC_WIDTH-1:0] cfg_inc_i,
  output logic                 rtc_o,
  output logic                 tick_o,
  output logic [63:0]          tick_count_o,
  output logic                 overrun_o
);
  localparam int HW = $clog2(MIN_HALF_PERIOD + 1);
  localparam logic [HW-1:0] HMIN = HW'(MIN_HALF_PERIOD);
  cfg_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] inc_q, inc_d, shadow_q, shadow_d;
  logic [HW-1:0]        half_cnt;
  logic                 carry, sat, toggle, drop, hs, pending, pending_d;
  rtc_phase_acc #(.W(ACC_WIDTH)) u_acc (
    .clk   (aclk),
    .rst   (areset),
    .enable(enable_i),
    .inc   (inc_q),
    .carry (carry)
  );
  // A carry arriving too early is owed once via pending; a second early carry is lost.
  always_comb begin
    sat = half_cnt >= HMIN;
    toggle = enable_i & sat & (carry | pending);
    drop = carry & ~sat & pending;
    pending_d = ~enable_i ? 1'b0 : (carry & ~sat) ? 1'b1 : (~carry & sat) ? 1'b0 : pending;
    cfg_ready_o = state_q == CFG_IDLE;
    hs = cfg_valid_i & cfg_ready_o;
    state_d = (state_q == CFG_IDLE) ? ((hs & enable_i) ? CFG_SHADOW : CFG_IDLE)
                                    : ((toggle | ~enable_i) ? CFG_IDLE : CFG_SHADOW);
    inc_d = (hs & ~enable_i) ? cfg_inc_i
          : (state_q == CFG_SHADOW && (toggle | ~enable_i)) ? shadow_q : inc_q;
    shadow_d = (hs & enable_i) ? cfg_inc_i : shadow_q;
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state_q <= CFG_IDLE;
      inc_q <= DEFAULT_INC;
      shadow_q <= '0;
      pending <= 1'b0;
      half_cnt <= HMIN;
      rtc_o <= 1'b0;
      tick_o <= 1'b0;
      tick_count_o <= '0;
      overrun_o <= 1'b0;
    end else begin
      state_q <= state_d;
      inc_q <= inc_d;
      shadow_q <= shadow_d;
      pending <= pending_d;
      half_cnt <= toggle ? HW'(1) : sat ? half_cnt : half_cnt + HW'(1);
      rtc_o <= rtc_o ^ toggle;
      tick_o <= toggle & ~rtc_o;
      tick_count_o <= tick_count_o + 64'(toggle & ~rtc_o);
      overrun_o <= drop | (overrun_o & ~hs);
    end
endmodule

// File: tb/tb_clint_rtc_gen.sv
// tb_clint_rtc_gen: directed self-checking bench for clint_rtc_gen (8-bit accumulator, default inc 64)
module tb_clint_rtc_gen;
  logic        aclk, areset, enable_i, cfg_valid_i, cfg_ready_o, rtc_o, tick_o, overrun_o;
  logic [7:0]  cfg_inc_i;
  logic [63:0] tick_count_o;
  int checks = 0;
  int fails = 0;

  clint_rtc_gen #(.ACC_WIDTH(8), .DEFAULT_INC(8'd64), .MIN_HALF_PERIOD(2)) dut (
    .aclk        (aclk),
    .areset      (areset),
    .enable_i    (enable_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_inc_i   (cfg_inc_i),
    .rtc_o       (rtc_o),
    .tick_o      (tick_o),
    .tick_count_o(tick_count_o),
    .overrun_o   (overrun_o)
  );

  initial aclk = 0;
  always #5 aclk = ~aclk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic do_reset();
    areset = 1; enable_i = 0; cfg_valid_i = 0; cfg_inc_i = 0;
    step(1);
    areset = 0;
  endtask

  task automatic program_inc(input logic [7:0] v);
    enable_i = 0; cfg_valid_i = 1; cfg_inc_i = v;
    step(1);
    cfg_valid_i = 0;
  endtask

  task automatic test_reset();
    areset = 1; enable_i = 0; cfg_valid_i = 0; cfg_inc_i = 0;
    #1;
    checks++; if (rtc_o !== 1'b0) begin fails++; $display("FAIL reset_rtc got %b exp 0", rtc_o); end
    checks++; if (tick_o !== 1'b0) begin fails++; $display("FAIL reset_tick got %b exp 0", tick_o); end
    checks++; if (tick_count_o !== 64'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", tick_count_o); end
    checks++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b exp 0", overrun_o); end
    checks++; if (cfg_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", cfg_ready_o); end
    step(1);
    areset = 0;
  endtask

  task automatic test_basic();
    do_reset();
    enable_i = 1;
    for (int e = 1; e <= 20; e++) begin
      logic er, et;
      step(1);
      er = ((e / 4) % 2) == 1;
      et = (e % 8) == 4;
      checks++; if (rtc_o !== er) begin fails++; $display("FAIL basic_rtc e=%0d got %b exp %b", e, rtc_o, er); end
      checks++; if (tick_o !== et) begin fails++; $display("FAIL basic_tick e=%0d got %b exp %b", e, tick_o, et); end
    end
    checks++; if (tick_count_o !== 64'd3) begin fails++; $display("FAIL basic_count got %0d exp 3", tick_count_o); end
  endtask

  task automatic test_frac();
    logic [7:0] exp_rtc;
    exp_rtc = 8'b1001_1100;
    do_reset();
    program_inc(8'd96);
    enable_i = 1;
    for (int e = 1; e <= 8; e++) begin
      step(1);
      checks++; if (rtc_o !== exp_rtc[e-1]) begin fails++; $display("FAIL frac_rtc e=%0d got %b exp %b", e, rtc_o, exp_rtc[e-1]); end
    end
    checks++; if (tick_count_o !== 64'd2) begin fails++; $display("FAIL frac_count8 got %0d exp 2", tick_count_o); end
    step(56);
    checks++; if (tick_count_o !== 64'd12) begin fails++; $display("FAIL frac_count64 got %0d exp 12", tick_count_o); end
    checks++; if (rtc_o !== 1'b0) begin fails++; $display("FAIL frac_rtc64 got %b exp 0", rtc_o); end
    checks++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL frac_overrun got %b exp 0", overrun_o); end
  endtask

  task automatic test_overrun();
    do_reset();
    program_inc(8'd255);
    enable_i = 1;
    step(1);
    checks++; if (rtc_o !== 1'b0) begin fails++; $display("FAIL ovr_rtc1 got %b exp 0", rtc_o); end
    step(1);
    checks++; if (rtc_o !== 1'b1) begin fails++; $display("FAIL ovr_rtc2 got %b exp 1", rtc_o); end
    checks++; if (tick_o !== 1'b1) begin fails++; $display("FAIL ovr_tick2 got %b exp 1", tick_o); end
    step(1);
    checks++; if (rtc_o !== 1'b1) begin fails++; $display("FAIL ovr_rtc3 got %b exp 1", rtc_o); end
    checks++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL ovr_early got %b exp 0", overrun_o); end
    step(3);
    checks++; if (overrun_o !== 1'b1) begin fails++; $display("FAIL ovr_set got %b exp 1", overrun_o); end
    program_inc(8'd64);
    checks++; if (overrun_o !== 1'b0) begin fails++; $display("FAIL ovr_clear got %b exp 0", overrun_o); end
    checks++; if (cfg_ready_o !== 1'b1) begin fails++; $display("FAIL ovr_ready got %b exp 1", cfg_ready_o); end
  endtask

  task automatic test_reconfig();
    do_reset();
    enable_i = 1;
    step(6);
    cfg_valid_i = 1; cfg_inc_i = 8'd32;
    step(1);
    cfg_valid_i = 0;
    checks++; if (cfg_ready_o !== 1'b0) begin fails++; $display("FAIL rcfg_ready7 got %b exp 0", cfg_ready_o); end
    checks++; if (rtc_o !== 1'b1) begin fails++; $display("FAIL rcfg_rtc7 got %b exp 1", rtc_o); end
    step(1);
    checks++; if (cfg_ready_o !== 1'b1) begin fails++; $display("FAIL rcfg_ready8 got %b exp 1", cfg_ready_o); end
    checks++; if (rtc_o !== 1'b0) begin fails++; $display("FAIL rcfg_rtc8 got %b exp 0", rtc_o); end
    for (int e = 9; e <= 15; e++) begin
      step(1);
      checks++; if (rtc_o !== 1'b0) begin fails++; $display("FAIL rcfg_hold e=%0d got %b exp 0", e, rtc_o); end
    end
    step(1);
    checks++; if (rtc_o !== 1'b1) begin fails++; $display("FAIL rcfg_rtc16 got %b exp 1", rtc_o); end
    checks++; if (tick_o !== 1'b1) begin fails++; $display("FAIL rcfg_tick16 got %b exp 1", tick_o); end
  endtask

  task automatic test_freeze();
    do_reset();
    enable_i = 1;
    step(5);
    checks++; if (rtc_o !== 1'b1) begin fails++; $display("FAIL frz_rtc5 got %b exp 1", rtc_o); end
    enable_i = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++; if (rtc_o !== 1'b1 || tick_o !== 1'b0) begin fails++; $display("FAIL frz_hold i=%0d got rtc %b tick %b exp rtc 1 tick 0", i, rtc_o, tick_o); end
    end
    enable_i = 1;
    step(2);
    checks++; if (rtc_o !== 1'b1) begin fails++; $display("FAIL frz_resume2 got %b exp 1", rtc_o); end
    step(1);
    checks++; if (rtc_o !== 1'b0) begin fails++; $display("FAIL frz_resume3 got %b exp 0", rtc_o); end
    checks++; if (tick_count_o !== 64'd1) begin fails++; $display("FAIL frz_count got %0d exp 1", tick_count_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable_i = 1;
    step(5);
    cfg_valid_i = 1; cfg_inc_i = 8'd200;
    step(1);
    cfg_valid_i = 0;
    checks++; if (cfg_ready_o !== 1'b0) begin fails++; $display("FAIL arst_shadow got %b exp 0", cfg_ready_o); end
    #2 areset = 1;
    #1;
    checks++; if (rtc_o !== 1'b0) begin fails++; $display("FAIL arst_rtc got %b exp 0", rtc_o); end
    checks++; if (tick_count_o !== 64'd0) begin fails++; $display("FAIL arst_count got %0d exp 0", tick_count_o); end
    checks++; if (cfg_ready_o !== 1'b1) begin fails++; $display("FAIL arst_ready got %b exp 1", cfg_ready_o); end
    checks++; if (overrun_o !== 1'b0 || tick_o !== 1'b0) begin fails++; $display("FAIL arst_flags got ovr %b tick %b exp 0 0", overrun_o, tick_o); end
    step(1);
    areset = 0;
    step(3);
    checks++; if (rtc_o !== 1'b0) begin fails++; $display("FAIL arst_rtc3 got %b exp 0", rtc_o); end
    step(1);
    checks++; if (rtc_o !== 1'b1) begin fails++; $display("FAIL arst_rtc4 got %b exp 1", rtc_o); end
    checks++; if (tick_o !== 1'b1) begin fails++; $display("FAIL arst_tick4 got %b exp 1", tick_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frac();
    test_overrun();
    test_reconfig();
    test_freeze();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
